level_timer: RTL and testbench
==============================

LEVEL_TIMER -- requirements
Module: level_timer

Interface
- REQ-001: Parameter WARN_SEC, default 10, is the remaining-seconds threshold at or below which warning asserts (legal 0..99).
- REQ-002: Parameter BONUS_SEC, default 5, is the seconds added per bonus pulse (legal 1..99).
- REQ-003: clk  input  1  system clock; every register updates on its rising edge.
- REQ-004: reset  input  1  synchronous, active-high reset.
- REQ-005: one_sec  input  1  single-cycle tick from the slow-clock counter; one pulse per elapsed second.
- REQ-006: start  input  1  single-cycle pulse; loads the timer and begins counting.
- REQ-007: pause  input  1  single-cycle pulse; toggles between running and paused.
- REQ-008: bonus  input  1  single-cycle pulse; adds BONUS_SEC seconds.
- REQ-009: load_value  input  7  start time in binary seconds, sampled only when start is high.
- REQ-010: tens  output  4  BCD tens digit of the remaining time (0..9).
- REQ-011: units  output  4  BCD units digit of the remaining time (0..9).
- REQ-012: running  output  1  high while the FSM is in RUN.
- REQ-013: warning  output  1  high while in RUN or PAUSED with remaining time <= WARN_SEC.
- REQ-014: expired  output  1  high while the FSM is in EXPIRED.
- REQ-015: time_up  output  1  single-cycle pulse on entry to EXPIRED.

Function
- REQ-016: FSM states are IDLE, RUN, PAUSED and EXPIRED; all outputs are registered; every input effect is visible on the cycle after it is sampled.
- REQ-017: Remaining time is held as two BCD digits, range 00..99.
- REQ-018: start in any state loads min(load_value, 99) converted to BCD.
  - If the loaded value is nonzero, the next state is RUN.
  - If the loaded value is zero, the next state is EXPIRED and time_up pulses.
- REQ-019: start has priority over pause, bonus and one_sec in the same cycle; the coincident inputs are discarded.
- REQ-020: In RUN, one_sec decrements the time by 1.
  - If units is 0, units becomes 9 and tens decrements.
  - When the result is 00, the next state is EXPIRED and time_up pulses for exactly one cycle.
- REQ-021: In RUN, pause moves to PAUSED; in PAUSED, pause moves to RUN; pause is ignored in IDLE and EXPIRED.
- REQ-022: one_sec coincident with pause in RUN: the decrement is applied and the state moves to PAUSED; if that decrement reaches 00, EXPIRED wins.
- REQ-023: one_sec in IDLE, PAUSED or EXPIRED is ignored; time holds.
- REQ-024: bonus in RUN or PAUSED adds BONUS_SEC, saturating at 99.
  - Coincident with one_sec in RUN, the net change is +BONUS_SEC-1 (saturated at 99); this never causes expiry.
  - bonus in IDLE or EXPIRED is ignored.
- REQ-025: The time holds at 00 in EXPIRED; the block leaves EXPIRED only on start or reset.
- REQ-026: tens and units never hold a non-BCD code (A..F) in any state.
- REQ-027: time_up never asserts for two consecutive cycles.

Reset
- REQ-028: reset has priority over all other inputs.
- REQ-029: On the cycle after reset is sampled high: state = IDLE, tens = 0, units = 0, and running, warning, expired and time_up are all 0.
- REQ-030: Reset asserted mid-RUN or mid-time_up clears everything as in REQ-029; no further time_up pulse follows.

Verification
- REQ-031: start with load_value=12, then 3 one_sec pulses -> tens:units = 1:2, 1:1, 1:0, 0:9; running=1; warning rises when 1:0 is reached.
- REQ-032: start with load_value=2, then 2 one_sec pulses -> 0:1, then 0:0 with time_up=1 for one cycle, expired=1, running=0; further one_sec pulses keep 0:0.
- REQ-033: Run at 4:5, pause, then 5 one_sec pulses, then pause -> time stays 4:5 while paused; the next one_sec after resuming gives 4:4.
- REQ-034: Time 9:7 with bonus -> 9:9 (saturated); time 2:0 with bonus and one_sec in the same cycle -> 2:4.
- REQ-035: load_value=120 with start -> 9:9; load_value=0 with start -> expired=1 and a single time_up pulse.
- REQ-036: reset during RUN at 0:1 coincident with one_sec -> 0:0 in IDLE, time_up=0, expired=0.

Source files
------------

// File: rtl/level_timer.sv
// level_timer: two-digit BCD countdown timer with start/pause/bonus control.
//
// Ports:
//   clk         - system clock, all registers update on rising edge
//   reset       - synchronous active-high reset
//   one_sec     - one-cycle tick per elapsed second
//   start       - one-cycle pulse, loads min(load_value, 99) and starts counting
//   pause       - one-cycle pulse, toggles RUN <-> PAUSED
//   bonus       - one-cycle pulse, adds BONUS_SEC (saturating at 99)
//   load_value  - start time in binary seconds, sampled with start
//   tens, units - BCD digits of the remaining time
//   running     - high in RUN
//   warning     - high in RUN/PAUSED when remaining time <= WARN_SEC
//   expired     - high in EXPIRED
//   time_up     - one-cycle pulse on entry to EXPIRED
module level_timer #(
  parameter int unsigned WARN_SEC  = 10,
  parameter int unsigned BONUS_SEC = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       one_sec,
  input  logic       start,
  input  logic       pause,
  input  logic       bonus,
  input  logic [6:0] load_value,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       running,
  output logic       warning,
  output logic       expired,
  output logic       time_up
);

  localparam int unsigned TIME_W  = 7;
  localparam int unsigned SUM_W   = 8;
  localparam int unsigned DIGIT_W = 4;
  localparam logic [TIME_W-1:0] MAX_SEC  = TIME_W'(99);
  localparam logic [TIME_W-1:0] WARN_LIM = TIME_W'(WARN_SEC);
  localparam logic [SUM_W-1:0]  BONUS_INC = SUM_W'(BONUS_SEC);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [DIGIT_W-1:0]   tens_q, tens_d;
  logic [DIGIT_W-1:0]   units_q, units_d;
  logic                 running_q, running_d;
  logic                 warning_q, warning_d;
  logic                 expired_q, expired_d;
  logic                 time_up_q, time_up_d;

  logic [TIME_W-1:0]    cur_bin;
  logic [TIME_W-1:0]    load_sat;
  logic [TIME_W-1:0]    dec_bin;
  logic [SUM_W-1:0]     bonus_sum;
  logic [TIME_W-1:0]    bonus_sat;
  logic [TIME_W-1:0]    bin_d;
  logic                 tick_run;

  // Arithmetic is done in binary; the stored digits are always re-derived
  // from a value clamped to 0..99, so they can never hold A..F.
  always_comb begin
    cur_bin   = TIME_W'(tens_q) * TIME_W'(10) + TIME_W'(units_q);
    load_sat  = (load_value > MAX_SEC) ? MAX_SEC : load_value;
    dec_bin   = cur_bin - TIME_W'(1);
    tick_run  = one_sec && (state_q == ST_RUN);
    // Coincident tick in RUN is folded in before saturation: net +BONUS-1.
    bonus_sum = SUM_W'(cur_bin) + BONUS_INC - SUM_W'(tick_run);
    bonus_sat = (bonus_sum > SUM_W'(MAX_SEC)) ? MAX_SEC : TIME_W'(bonus_sum);
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d   = state_q;
    bin_d     = cur_bin;
    tens_d    = tens_q;
    units_d   = units_q;
    running_d = 1'b0;
    warning_d = 1'b0;
    expired_d = 1'b0;
    time_up_d = 1'b0;

    if (start) begin
      // start overrides every coincident input
      bin_d   = load_sat;
      state_d = (load_sat == '0) ? ST_EXPIRED : ST_RUN;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_RUN: begin
          if (bonus) begin
            bin_d = bonus_sat;
            if (pause) state_d = ST_PAUSED;
          end else if (one_sec) begin
            bin_d = dec_bin;
            if (dec_bin == '0) state_d = ST_EXPIRED;
            else if (pause)    state_d = ST_PAUSED;
          end else if (pause) begin
            state_d = ST_PAUSED;
          end
        end
        ST_PAUSED: begin
          if (bonus) bin_d = bonus_sat;
          if (pause) state_d = ST_RUN;
        end
        ST_EXPIRED: begin
          bin_d = '0;
        end
        default: begin
          state_d = ST_IDLE;
          bin_d   = '0;
        end
      endcase
    end

    tens_d    = DIGIT_W'(bin_d / TIME_W'(10));
    units_d   = DIGIT_W'(bin_d % TIME_W'(10));
    running_d = (state_d == ST_RUN);
    expired_d = (state_d == ST_EXPIRED);
    warning_d = ((state_d == ST_RUN) || (state_d == ST_PAUSED)) && (bin_d <= WARN_LIM);
    // Pulse on entry to EXPIRED (including a zero reload), never back to back.
    time_up_d = (state_d == ST_EXPIRED) && ((state_q != ST_EXPIRED) || start) && !time_up_q;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      tens_q    <= '0;
      units_q   <= '0;
      running_q <= 1'b0;
      warning_q <= 1'b0;
      expired_q <= 1'b0;
      time_up_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tens_q    <= tens_d;
      units_q   <= units_d;
      running_q <= running_d;
      warning_q <= warning_d;
      expired_q <= expired_d;
      time_up_q <= time_up_d;
    end
  end

  assign tens    = tens_q;
  assign units   = units_q;
  assign running = running_q;
  assign warning = warning_q;
  assign expired = expired_q;
  assign time_up = time_up_q;

endmodule

// File: tb/tb_level_timer.sv
// tb_level_timer: directed vectors for level_timer with a queue-based scoreboard.
// Each vector drives one cycle of inputs at the falling edge and pushes the
// hand-computed outputs expected after the next rising edge; the monitor pops
// and compares one entry per rising edge.
module tb_level_timer;

  logic       clk;
  logic       reset;
  logic       one_sec;
  logic       start;
  logic       pause;
  logic       bonus;
  logic [6:0] load_value;
  logic [3:0] tens;
  logic [3:0] units;
  logic       running;
  logic       warning;
  logic       expired;
  logic       time_up;

  level_timer #(.WARN_SEC(10), .BONUS_SEC(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .one_sec    (one_sec),
    .start      (start),
    .pause      (pause),
    .bonus      (bonus),
    .load_value (load_value),
    .tens       (tens),
    .units      (units),
    .running    (running),
    .warning    (warning),
    .expired    (expired),
    .time_up    (time_up)
  );

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
    logic       running;
    logic       warning;
    logic       expired;
    logic       time_up;
  } obs_t;

  typedef struct {
    string name;
    obs_t  obs;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec;
  int   n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of stimulus and queue the expected post-edge outputs.
  task automatic vec(input string nm, input logic r, input logic s, input logic p,
                     input logic b, input logic o, input logic [6:0] lv,
                     input logic [3:0] et, input logic [3:0] eu, input logic er,
                     input logic ew, input logic ee, input logic etu);
    exp_t e;
    @(negedge clk);
    reset      = r;
    start      = s;
    pause      = p;
    bonus      = b;
    one_sec    = o;
    load_value = lv;
    e.name = nm;
    e.obs  = '{tens: et, units: eu, running: er, warning: ew, expired: ee, time_up: etu};
    exp_q.push_back(e);
  endtask

  // Monitor: compare one queued expectation per rising edge.
  initial begin
    exp_t e;
    obs_t act;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = '{tens: tens, units: units, running: running, warning: warning,
                expired: expired, time_up: time_up};
        n_vec++;
        if (act !== e.obs) begin
          n_err++;
          $display("FAIL %s: got t=%0d u=%0d run=%b warn=%b exp=%b tup=%b, want t=%0d u=%0d run=%b warn=%b exp=%b tup=%b",
                   e.name, act.tens, act.units, act.running, act.warning, act.expired, act.time_up,
                   e.obs.tens, e.obs.units, e.obs.running, e.obs.warning, e.obs.expired, e.obs.time_up);
        end
      end
    end
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1; start = 1'b0; pause = 1'b0; bonus = 1'b0; one_sec = 1'b0; load_value = '0;

    //    name          r  s  p  b  o  load    t  u  run warn exp tup
    vec("reset",        1, 0, 0, 0, 0, 7'd0,   0, 0, 0, 0, 0, 0);
    vec("idle_tick",    0, 0, 0, 0, 1, 7'd0,   0, 0, 0, 0, 0, 0);
    vec("idle_pb",      0, 0, 1, 1, 0, 7'd0,   0, 0, 0, 0, 0, 0);
    // count down from 12
    vec("ld12",         0, 1, 0, 0, 0, 7'd12,  1, 2, 1, 0, 0, 0);
    vec("c11",          0, 0, 0, 0, 1, 7'd0,   1, 1, 1, 0, 0, 0);
    vec("c10_warn",     0, 0, 0, 0, 1, 7'd0,   1, 0, 1, 1, 0, 0);
    vec("c09_borrow",   0, 0, 0, 0, 1, 7'd0,   0, 9, 1, 1, 0, 0);
    vec("hold09",       0, 0, 0, 0, 0, 7'd0,   0, 9, 1, 1, 0, 0);
    // expiry
    vec("ld2",          0, 1, 0, 0, 0, 7'd2,   0, 2, 1, 1, 0, 0);
    vec("c01",          0, 0, 0, 0, 1, 7'd0,   0, 1, 1, 1, 0, 0);
    vec("c00_tup",      0, 0, 0, 0, 1, 7'd0,   0, 0, 0, 0, 1, 1);
    vec("exp_tick",     0, 0, 0, 0, 1, 7'd0,   0, 0, 0, 0, 1, 0);
    vec("exp_pb",       0, 0, 1, 1, 0, 7'd0,   0, 0, 0, 0, 1, 0);
    // pause holds time
    vec("ld45",         0, 1, 0, 0, 0, 7'd45,  4, 5, 1, 0, 0, 0);
    vec("pause",        0, 0, 1, 0, 0, 7'd0,   4, 5, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      vec("paused_tick",0, 0, 0, 0, 1, 7'd0,   4, 5, 0, 0, 0, 0);
    vec("resume",       0, 0, 1, 0, 0, 7'd0,   4, 5, 1, 0, 0, 0);
    vec("c44",          0, 0, 0, 0, 1, 7'd0,   4, 4, 1, 0, 0, 0);
    vec("pause_tick",   0, 0, 1, 0, 1, 7'd0,   4, 3, 0, 0, 0, 0);
    vec("paused_bonus", 0, 0, 0, 1, 0, 7'd0,   4, 8, 0, 0, 0, 0);
    vec("resume48",     0, 0, 1, 0, 0, 7'd0,   4, 8, 1, 0, 0, 0);
    // bonus saturation and bonus+tick
    vec("ld97",         0, 1, 0, 0, 0, 7'd97,  9, 7, 1, 0, 0, 0);
    vec("bonus_sat",    0, 0, 0, 1, 0, 7'd0,   9, 9, 1, 0, 0, 0);
    vec("ld97b",        0, 1, 0, 0, 0, 7'd97,  9, 7, 1, 0, 0, 0);
    vec("bonus_tick_sat",0,0, 0, 1, 1, 7'd0,   9, 9, 1, 0, 0, 0);
    vec("ld20",         0, 1, 0, 0, 0, 7'd20,  2, 0, 1, 0, 0, 0);
    vec("bonus_tick",   0, 0, 0, 1, 1, 7'd0,   2, 4, 1, 0, 0, 0);
    vec("start_prio",   0, 1, 1, 1, 1, 7'd5,   0, 5, 1, 1, 0, 0);
    // load clamp and zero load
    vec("ld120",        0, 1, 0, 0, 0, 7'd120, 9, 9, 1, 0, 0, 0);
    vec("ld0",          0, 1, 0, 0, 0, 7'd0,   0, 0, 0, 0, 1, 1);
    vec("ld0_after",    0, 0, 0, 0, 0, 7'd0,   0, 0, 0, 0, 1, 0);
    vec("reld0",        0, 1, 0, 0, 0, 7'd0,   0, 0, 0, 0, 1, 1);
    vec("reld0_again",  0, 1, 0, 0, 0, 7'd0,   0, 0, 0, 0, 1, 0);
    vec("exp_ld3",      0, 1, 0, 0, 0, 7'd3,   0, 3, 1, 1, 0, 0);
    // warning boundary while paused
    vec("ld10",         0, 1, 0, 0, 0, 7'd10,  1, 0, 1, 1, 0, 0);
    vec("ld11",         0, 1, 0, 0, 0, 7'd11,  1, 1, 1, 0, 0, 0);
    vec("c10",          0, 0, 0, 0, 1, 7'd0,   1, 0, 1, 1, 0, 0);
    vec("pause10",      0, 0, 1, 0, 0, 7'd0,   1, 0, 0, 1, 0, 0);
    // reset coincident with final tick
    vec("ld1",          0, 1, 0, 0, 0, 7'd1,   0, 1, 1, 1, 0, 0);
    vec("rst_tick",     1, 0, 0, 0, 1, 7'd0,   0, 0, 0, 0, 0, 0);
    vec("post_rst",     0, 0, 0, 0, 1, 7'd0,   0, 0, 0, 0, 0, 0);
    // reset during the time_up pulse
    vec("ld1b",         0, 1, 0, 0, 0, 7'd1,   0, 1, 1, 1, 0, 0);
    vec("c00b",         0, 0, 0, 0, 1, 7'd0,   0, 0, 0, 0, 1, 1);
    vec("rst_tup",      1, 0, 0, 0, 0, 7'd0,   0, 0, 0, 0, 0, 0);
    vec("idle_after",   0, 0, 0, 0, 0, 7'd0,   0, 0, 0, 0, 0, 0);

    @(negedge clk);
    reset = 1'b0; start = 1'b0; pause = 1'b0; bonus = 1'b0; one_sec = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
